// File: rtl/arinc429_tx_scheduler.sv
// ============================================================================
// Module   : arinc429_tx_scheduler
// Brief    : Round-robin word scheduler driving the ARINC429 transmitter st/adr/dat/nvel
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arinc429_tx_scheduler #(
  parameter int DIV_LO    = 4000,
  parameter int DIV_MID   = 1000,
  parameter int DIV_HI    = 500,
  parameter int GAP_BITS  = 4,
  parameter int ST_CYCLES = 2
) (
  input  logic        GCLK,
  input  logic        rst,
  input  logic [1:0]  nvel_cfg,
  input  logic [3:0]  req,
  input  logic [31:0] req_adr,
  input  logic [91:0] req_dat,
  output logic [3:0]  gnt,
  output logic        st,
  output logic [7:0]  adr,
  output logic [22:0] dat,
  output logic [1:0]  nvel,
  output logic        busy,
  output logic [1:0]  cur_id
);

  localparam int          CNT_W          = 32;
  localparam logic [31:0] C_SLOT_LO_M1   = 32'((32 + GAP_BITS) * DIV_LO - 1);
  localparam logic [31:0] C_SLOT_MID_M1  = 32'((32 + GAP_BITS) * DIV_MID - 1);
  localparam logic [31:0] C_SLOT_HI_M1   = 32'((32 + GAP_BITS) * DIV_HI - 1);
  localparam logic [3:0]  C_PULSE_M1     = 4'(ST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   slot_q, slot_d;
  logic [3:0]         pulse_q, pulse_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         gnt_q, gnt_d;
  logic               st_q, st_d;
  logic               busy_q, busy_d;
  logic [7:0]         adr_q, adr_d;
  logic [22:0]        dat_q, dat_d;
  logic [1:0]         nvel_q, nvel_d;
  logic [1:0]         cur_id_q, cur_id_d;

  logic [1:0]         w_win;
  logic [1:0]         w_idx;
  logic               w_found;
  logic               w_grant;
  logic [CNT_W-1:0]   w_slot_m1;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_win   = ptr_q;
    w_idx   = ptr_q;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = ptr_q + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (nvel_cfg)
      2'd0:    w_slot_m1 = C_SLOT_LO_M1;
      2'd1:    w_slot_m1 = C_SLOT_MID_M1;
      default: w_slot_m1 = C_SLOT_HI_M1;
    endcase
  end

  assign w_grant = w_found &&
                   ((state_q == S_IDLE) || ((state_q == S_WAIT) && (slot_q == '0)));

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    pulse_d  = pulse_q;
    ptr_d    = ptr_q;
    gnt_d    = 4'b0000;
    st_d     = st_q;
    busy_d   = busy_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    nvel_d   = nvel_q;
    cur_id_d = cur_id_q;

    if ((state_q != S_IDLE) && (slot_q != '0)) begin
      slot_d = slot_q - 1'b1;
    end

    unique case (state_q)
      S_START: begin
        if (pulse_q == 4'd0) begin
          st_d    = 1'b0;
          state_d = S_WAIT;
        end else begin
          pulse_d = pulse_q - 4'd1;
        end
      end
      S_WAIT: begin
        if (slot_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase

    // A grant overrides the slot-end return to IDLE, giving back-to-back words.
    if (w_grant) begin
      state_d  = S_START;
      slot_d   = w_slot_m1;
      pulse_d  = C_PULSE_M1;
      ptr_d    = w_win;
      gnt_d    = 4'b0001 << w_win;
      st_d     = 1'b1;
      busy_d   = 1'b1;
      adr_d    = req_adr[8*w_win +: 8];
      dat_d    = req_dat[23*w_win +: 23];
      nvel_d   = nvel_cfg;
      cur_id_d = w_win;
    end
  end

  always_ff @(posedge GCLK) begin
    if (rst) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      pulse_q  <= 4'd0;
      ptr_q    <= 2'd3;
      gnt_q    <= 4'b0000;
      st_q     <= 1'b0;
      busy_q   <= 1'b0;
      adr_q    <= 8'd0;
      dat_q    <= 23'd0;
      nvel_q   <= 2'd0;
      cur_id_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      pulse_q  <= pulse_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      st_q     <= st_d;
      busy_q   <= busy_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      nvel_q   <= nvel_d;
      cur_id_q <= cur_id_d;
    end
  end

  assign gnt    = gnt_q;
  assign st     = st_q;
  assign busy   = busy_q;
  assign adr    = adr_q;
  assign dat    = dat_q;
  assign nvel   = nvel_q;
  assign cur_id = cur_id_q;

endmodule

`default_nettype wire
